// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry IF/ID skid buffer with HALT tracking, branch flush and pc_stop back-pressure.
// Optional macro IF_ID_STATS_EN adds saturating stall_cycles / flushed_entries counters.
module if_id_buffer #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [3:0]        HALT_OPCODE = 4'hF,
    parameter logic [DATA_W-1:0] NOP_INSTR   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instruction,
    input  logic [ADDR_W-1:0] if_instruction_address,
    input  logic [ADDR_W-1:0] if_adder_result_address,
    output logic              if_pc_stop,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instruction,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus2,
    input  logic              flush,
    output logic              halted
`ifdef IF_ID_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flushed_entries
`endif
);
    localparam logic [1:0] RUN          = 2'd0;
    localparam logic [1:0] HALT_PENDING = 2'd1;
    localparam logic [1:0] HALTED       = 2'd2;

    logic [DATA_W-1:0] instr_q [2];
    logic [ADDR_W-1:0] pc_q    [2];
    logic [ADDR_W-1:0] pc2_q   [2];
    logic [1:0]        state_q, state_d, count_q, count_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              push, pop, is_halt;

    assign if_pc_stop     = (count_q == 2'd2) || (state_q != RUN);
    assign id_valid       = count_q != 2'd0;
    assign halted         = state_q == HALTED;
    assign push           = if_valid && !if_pc_stop;
    assign pop            = id_valid && id_ready;
    assign is_halt        = if_instruction[DATA_W-1 -: 4] == HALT_OPCODE;
    assign id_instruction = id_valid ? instr_q[rd_q] : NOP_INSTR;
    assign id_pc          = id_valid ? pc_q[rd_q] : '0;
    assign id_pc_plus2    = id_valid ? pc2_q[rd_q] : '0;

    // Once HALT is queued no more pushes happen, so the last entry to pop is the HALT.
    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        rd_d    = rd_q ^ pop;
        wr_d    = wr_q ^ push;
        state_d = state_q;
        if (push && is_halt)
            state_d = HALT_PENDING;
        else if (state_q == HALT_PENDING && pop && count_q == 2'd1)
            state_d = HALTED;
        if (flush) begin
            count_d = '0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            instr_q[wr_q] <= if_instruction;
            pc_q[wr_q]    <= if_instruction_address;
            pc2_q[wr_q]   <= if_adder_result_address;
        end
    end

`ifdef IF_ID_STATS_EN
    logic [15:0] stall_q, flushed_q;
    logic [16:0] stall_sum, flushed_sum;

    assign stall_sum       = {1'b0, stall_q} + 17'(if_valid && if_pc_stop && state_q == RUN);
    assign flushed_sum     = {1'b0, flushed_q} + (flush ? 17'(count_q) + 17'(push) : 17'd0);
    assign stall_cycles    = stall_q;
    assign flushed_entries = flushed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
            flushed_q <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_if_id_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [15:0] if_instruction = '0;
    logic [15:0] if_instruction_address = '0;
    logic [15:0] if_adder_result_address = '0;
    logic        id_ready = 1'b0;
    logic        flush = 1'b0;
    logic        if_pc_stop, id_valid, halted;
    logic [15:0] id_instruction, id_pc, id_pc_plus2;
`ifdef IF_ID_STATS_EN
    logic [15:0] stall_cycles, flushed_entries;
`endif
    int checks = 0;
    int failures = 0;

    typedef struct packed {logic [15:0] i; logic [15:0] p; logic [15:0] p2;} ent_t;
    ent_t q[$];
    bit   m_pend, m_halt;
    int   m_stall, m_flushed;

    if_id_buffer dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_instruction(if_instruction),
        .if_instruction_address(if_instruction_address), .if_adder_result_address(if_adder_result_address),
        .if_pc_stop(if_pc_stop), .id_ready(id_ready), .id_valid(id_valid), .id_instruction(id_instruction),
        .id_pc(id_pc), .id_pc_plus2(id_pc_plus2), .flush(flush), .halted(halted)
`ifdef IF_ID_STATS_EN
        , .stall_cycles(stall_cycles), .flushed_entries(flushed_entries)
`endif
    );

    always #5 clock = ~clock;

    // Advance one clock; the reference model applies the rules to the inputs held across the edge.
    task automatic step();
        bit   stop;
        ent_t e;
        @(posedge clock);
        stop = q.size() == 2 || m_pend || m_halt;
        if (reset) begin
            q.delete(); m_pend = 0; m_halt = 0; m_stall = 0; m_flushed = 0;
        end else begin
            if (if_valid && stop && !m_pend && !m_halt) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (flush) begin
                m_flushed = m_flushed + q.size() + ((if_valid && !stop) ? 1 : 0);
                if (m_flushed > 65535) m_flushed = 65535;
                q.delete(); m_pend = 0; m_halt = 0;
            end else begin
                if (q.size() != 0 && id_ready) begin
                    e = q.pop_front();
                    if (m_pend && e.i[15:12] == 4'hF) begin m_pend = 0; m_halt = 1; end
                end
                if (if_valid && !stop) begin
                    q.push_back({if_instruction, if_instruction_address, if_adder_result_address});
                    if (if_instruction[15:12] == 4'hF) m_pend = 1;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p);
        if_valid = v; if_instruction = i; if_instruction_address = p; if_adder_result_address = p + 16'd2;
    endtask

    task automatic test_reset();
        reset = 1; step(); step(); reset = 0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
        checks++; if (id_instruction !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", id_instruction); end
        checks++; if (id_pc !== 16'h0000 || id_pc_plus2 !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0000/0000", id_pc, id_pc_plus2); end
        checks++; if (if_pc_stop !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_stop got=%0b/%0b exp=0/0", if_pc_stop, halted); end
    endtask

    task automatic test_single();
        id_ready = 1; drive(1, 16'h1234, 16'h0000); step(); drive(0, 0, 0);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", id_valid); end
        checks++; if (id_instruction !== 16'h1234) begin failures++; $display("FAIL single_instr got=%h exp=1234", id_instruction); end
        checks++; if (id_pc !== 16'h0000 || id_pc_plus2 !== 16'h0002) begin failures++; $display("FAIL single_pc got=%h/%h exp=0000/0002", id_pc, id_pc_plus2); end
        step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%0b exp=0", id_valid); end
    endtask

    task automatic test_full();
        id_ready = 0; drive(1, 16'hA001, 16'h0010); step(); drive(1, 16'hA002, 16'h0012); step();
        checks++; if (if_pc_stop !== 1'b1) begin failures++; $display("FAIL full_stop got=%0b exp=1", if_pc_stop); end
        drive(1, 16'hA003, 16'h0014); step(); drive(0, 0, 0);
        checks++; if (id_instruction !== 16'hA001 || if_pc_stop !== 1'b1) begin failures++; $display("FAIL full_ignore got=%h/%0b exp=a001/1", id_instruction, if_pc_stop); end
        id_ready = 1; step();
        checks++; if (id_instruction !== 16'hA002 || id_pc !== 16'h0012) begin failures++; $display("FAIL full_order got=%h@%h exp=a002@0012", id_instruction, id_pc); end
        checks++; if (if_pc_stop !== 1'b0) begin failures++; $display("FAIL full_stop_drop got=%0b exp=0", if_pc_stop); end
        step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL full_drain got=%0b exp=0", id_valid); end
    endtask

    task automatic test_halt();
        id_ready = 0; drive(1, 16'h1111, 16'h0020); step(); drive(1, 16'hF000, 16'h0022); step();
        checks++; if (if_pc_stop !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL halt_pending got=%0b/%0b exp=1/0", if_pc_stop, halted); end
        drive(1, 16'h3333, 16'h0024); id_ready = 1; step();
        checks++; if (id_instruction !== 16'hF000 || halted !== 1'b0) begin failures++; $display("FAIL halt_head got=%h/%0b exp=f000/0", id_instruction, halted); end
        step();
        checks++; if (halted !== 1'b1 || id_valid !== 1'b0) begin failures++; $display("FAIL halt_done got=%0b/%0b exp=1/0", halted, id_valid); end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (if_pc_stop !== 1'b1 || halted !== 1'b1 || id_valid !== 1'b0) begin failures++; $display("FAIL halt_hold cyc=%0d got=%0b/%0b/%0b exp=1/1/0", k, if_pc_stop, halted, id_valid); end
        end
        drive(0, 0, 0); flush = 1; step(); flush = 0;
        checks++; if (halted !== 1'b0 || if_pc_stop !== 1'b0) begin failures++; $display("FAIL halt_flush got=%0b/%0b exp=0/0", halted, if_pc_stop); end
    endtask

    task automatic test_flush_full();
        id_ready = 0; drive(1, 16'hB001, 16'h0030); step(); drive(1, 16'hB002, 16'h0032); step();
        drive(1, 16'hB003, 16'h0034); flush = 1; step(); flush = 0; drive(0, 0, 0);
        checks++; if (id_valid !== 1'b0 || id_instruction !== 16'h0000) begin failures++; $display("FAIL flush_full got=%0b/%h exp=0/0000", id_valid, id_instruction); end
        step();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_discard got=%0b exp=0", id_valid); end
    endtask

    task automatic test_flush_pending();
        id_ready = 0; drive(1, 16'hF123, 16'h0040); step(); drive(0, 0, 0);
        checks++; if (if_pc_stop !== 1'b1) begin failures++; $display("FAIL fp_stop got=%0b exp=1", if_pc_stop); end
        flush = 1; step(); flush = 0;
        checks++; if (if_pc_stop !== 1'b0 || halted !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL fp_clear got=%0b/%0b/%0b exp=0/0/0", if_pc_stop, halted, id_valid); end
        drive(1, 16'h2222, 16'h0050); step(); drive(0, 0, 0);
        checks++; if (id_valid !== 1'b1 || id_instruction !== 16'h2222) begin failures++; $display("FAIL fp_push got=%0b/%h exp=1/2222", id_valid, id_instruction); end
        id_ready = 1; step();
    endtask

    task automatic test_reset_mid();
        id_ready = 0; drive(1, 16'hC001, 16'h0060); step(); drive(1, 16'hC002, 16'h0062); step();
        reset = 1; flush = 1; step(); reset = 0; flush = 0; drive(0, 0, 0);
        checks++; if (id_valid !== 1'b0 || if_pc_stop !== 1'b0 || id_instruction !== 16'h0000 || id_pc !== 16'h0000 || id_pc_plus2 !== 16'h0000) begin failures++; $display("FAIL rst_full got=%0b/%0b/%h/%h/%h exp=0/0/0000/0000/0000", id_valid, if_pc_stop, id_instruction, id_pc, id_pc_plus2); end
        id_ready = 1; drive(1, 16'hF000, 16'h0070); step(); drive(0, 0, 0); step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rst_halted_pre got=%0b exp=1", halted); end
        reset = 1; step(); reset = 0;
        checks++; if (halted !== 1'b0 || if_pc_stop !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0b/%0b/%0b exp=0/0/0", halted, if_pc_stop, id_valid); end
`ifdef IF_ID_STATS_EN
        checks++; if (stall_cycles !== 16'd0 || flushed_entries !== 16'd0) begin failures++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stall_cycles, flushed_entries); end
`endif
    endtask

    task automatic test_random();
        logic [15:0] ins, ei, ep, ep2;
        for (int n = 0; n < 3000; n++) begin
            ins = 16'($urandom);
            ins[15:12] = ($urandom_range(0, 9) == 0) ? 4'hF : ((ins[15:12] == 4'hF) ? 4'hE : ins[15:12]);
            drive($urandom_range(0, 3) != 0, ins, 16'($urandom) & 16'hFFFE);
            id_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 24) == 0;
            reset = $urandom_range(0, 199) == 0;
            step();
            ei = q.size() != 0 ? q[0].i : 16'h0000;
            ep = q.size() != 0 ? q[0].p : 16'h0000;
            ep2 = q.size() != 0 ? q[0].p2 : 16'h0000;
            checks++; if (id_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", n, id_valid, q.size() != 0); end
            checks++; if (id_instruction !== ei || id_pc !== ep || id_pc_plus2 !== ep2) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h@%h/%h exp=%h@%h/%h", n, id_instruction, id_pc, id_pc_plus2, ei, ep, ep2); end
            checks++; if (if_pc_stop !== (q.size() == 2 || m_pend || m_halt)) begin failures++; $display("FAIL rnd_stop cyc=%0d got=%0b exp=%0b", n, if_pc_stop, q.size() == 2 || m_pend || m_halt); end
            checks++; if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", n, halted, m_halt); end
`ifdef IF_ID_STATS_EN
            checks++; if (stall_cycles !== 16'(m_stall) || flushed_entries !== 16'(m_flushed)) begin failures++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cycles, flushed_entries, m_stall, m_flushed); end
`endif
        end
        reset = 0; flush = 0; drive(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_halt();
        test_flush_full();
        test_flush_pending();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Receiving end of the fetch interface, instantiated in the IF/ID buffer slot of the cpu top.
- Accepts instruction, instruction address and address+2 from the fetch stage, and queues them in a 2-entry skid buffer.
- Drives pc_stop back to the program counter.
- Tracks HALT instructions through an FSM so fetch freezes cleanly.
- Presents the oldest entry to decode with a valid/ready handshake, and supports branch flush.

Parameters:
- DATA_W, 16, instruction width
- ADDR_W, 16, instruction address width
- HALT_OPCODE, 4'hF, value of instruction[15:12] that encodes HALT
- NOP_INSTR, 16'h0000, value driven on id_instruction when no valid entry

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents a valid instruction this cycle
- if_instruction  in  DATA_W  instruction from instruction memory
- if_instruction_address  in  ADDR_W  PC of that instruction
- if_adder_result_address  in  ADDR_W  PC+2 from fetch adder
- if_pc_stop  out  1  freeze program counter (combinational)
- id_ready  in  1  decode can accept (low = hazard stall)
- id_valid  out  1  head entry valid
- id_instruction  out  DATA_W  head instruction, NOP_INSTR when empty
- id_pc  out  ADDR_W  head PC, 0 when empty
- id_pc_plus2  out  ADDR_W  head PC+2, 0 when empty
- flush  in  1  branch/jump taken: squash all buffered entries
- halted  out  1  HALT has left buffer into decode; fetch frozen

Behaviour:
- Storage: 2 entries, each {instr, pc, pc+2}.
  - Read and write pointers are 1 bit; count is 0..2.
  - Pointers wrap modulo 2.
- Push: if_valid && !if_pc_stop. Entry is written at the write pointer on the clock edge.
- Pop: id_valid && id_ready. The read pointer advances.
- Push and pop in the same cycle are allowed only when count==1. Count is unchanged and order is preserved.
- if_pc_stop = (count==2) || (state != RUN).
  - It stays high when count==2 even if a pop occurs that cycle, so there is no push-when-full bypass.
- id_valid = (count != 0). Outputs reflect the head entry combinationally from storage, so latency is 1 cycle from push to id_valid.
- Empty outputs: id_instruction=NOP_INSTR, id_pc=0, id_pc_plus2=0.
- FSM states: RUN, HALT_PENDING, HALTED.
  - RUN -> HALT_PENDING when a pushed instruction has [15:12]==HALT_OPCODE. No further pushes are accepted.
  - HALT_PENDING -> HALTED when the HALT entry pops. halted=1, count=0, if_pc_stop=1.
  - HALTED holds until reset or flush.
- Entries older than the HALT still drain normally in HALT_PENDING.
- flush has priority over push and pop in the same cycle:
  - count<=0 and pointers<=0.
  - The same-cycle push is discarded.
  - State returns to RUN from HALT_PENDING or HALTED; halted<=0.
- flush together with reset: reset wins, with the same end state.
- reset (synchronous, mid-operation included): count=0, pointers=0, state=RUN, halted=0.
  - if_pc_stop=0, id_valid=0, id_instruction=NOP_INSTR, id_pc=0, id_pc_plus2=0.
  - Storage contents are don't-care.
- if_valid low with if_pc_stop low: no push, no state change.

Optional Feature:
- Macro IF_ID_STATS_EN.
- When defined, adds the following outputs. Each is 16 bits, saturating at 16'hFFFF, cleared by reset.
  - stall_cycles: increments each cycle if_valid && if_pc_stop && state==RUN.
  - flushed_entries: adds count, plus 1 if a push was discarded, on each flush.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then push 16'h1234 @pc 16'h0000 with id_ready=1 -> next cycle id_valid=1, id_instruction=16'h1234, id_pc=16'h0000, id_pc_plus2=16'h0002; pops and count returns to 0.
- id_ready=0, push 16'hA001 then 16'hA002 -> count=2, if_pc_stop=1; third push is ignored. Raise id_ready -> A001 then A002 appear in order; if_pc_stop drops the cycle after count<2.
- Push 16'h1111 then HALT 16'hF000 -> if_pc_stop=1 after HALT is accepted. 1111 pops, then F000 pops -> halted=1, if_pc_stop stays 1 for 10+ cycles.
- Two entries buffered, assert flush with if_valid=1 in the same cycle -> next cycle id_valid=0, id_instruction=16'h0000; the pushed instruction is not present.
- HALT_PENDING with HALT buffered, assert flush -> state RUN, if_pc_stop=0, halted=0; a subsequent push of 16'h2222 is accepted.
- Assert reset while count=2 and in HALTED -> next cycle all outputs at reset values. With IF_ID_STATS_EN, stall_cycles=0 and flushed_entries=0.
